// File: rtl/box_color_pkg.sv
// rtl/box_color_pkg.sv - shared types, LFSR constants and defaults for box_color_seq
package box_color_pkg;

  // Colour-draw controller states
  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 -> taps on bits 7,5,4,3
  localparam int               LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  // Default palette geometry
  localparam int DEF_PALETTE_SIZE = 18;
  localparam int DEF_IDX_W        = 5;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/box_color_lfsr.sv
// rtl/box_color_lfsr.sv - seedable free-running 8-bit LFSR with zero-seed guard
module box_color_lfsr
  import box_color_pkg::*;
(
  input  logic              clk_machine,
  input  logic              rst_machine,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;

  // Step every cycle; a load wins over the step and a zero seed would lock up, so it is replaced
  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      r_state <= LFSR_SEED;
    end else if (i_load) begin
      r_state <= (i_seed == '0) ? LFSR_SEED : i_seed;
    end else begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/box_color_seq.sv
// rtl/box_color_seq.sv - per-box colour index queue; random draws enabled by BOX_COLOR_RANDOM_EN
module box_color_seq
  import box_color_pkg::*;
#(
  parameter int NUM_BOXES    = 2,
  parameter int PALETTE_SIZE = DEF_PALETTE_SIZE,
  parameter int IDX_W        = DEF_IDX_W,
  parameter int MAX_TRIES    = 8
)(
  input  logic                       clk_machine,
  input  logic                       rst_machine,
  input  logic                       i_advance,
  input  logic                       i_mode,
  input  logic                       i_seed_load,
  input  logic [7:0]                 i_seed,
  output logic [NUM_BOXES*IDX_W-1:0] o_color_index,
  output logic                       o_busy,
  output logic                       o_update,
  output logic                       o_overrun
);

  logic [IDX_W-1:0] r_box [NUM_BOXES];
  logic             r_update;
  logic [IDX_W-1:0] w_newest;
  logic [IDX_W-1:0] w_seq;
  logic [IDX_W-1:0] w_new;
  logic             w_commit;

  assign w_newest = r_box[NUM_BOXES-1];
  assign w_seq    = (w_newest == IDX_W'(PALETTE_SIZE - 1)) ? '0 : w_newest + IDX_W'(1);

`ifdef BOX_COLOR_RANDOM_EN
  localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [IDX_W:0]   PAL_LIM  = (IDX_W + 1)'(PALETTE_SIZE);

  state_t            r_state;
  logic [TRY_W-1:0]  r_tries;
  logic              r_pend;
  logic              r_pend_mode;
  logic              r_overrun;
  logic [LFSR_W-1:0] w_lfsr;
  logic [IDX_W-1:0]  w_cand;
  logic              w_cand_ok;
  logic              w_take;
  logic              w_take_mode;
  logic              w_unused_lfsr;

  box_color_lfsr u_lfsr (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .i_load      (i_seed_load),
    .i_seed      (i_seed),
    .o_state     (w_lfsr)
  );

  // The candidate uses the LFSR value before any same-edge reload
  assign w_cand        = w_lfsr[IDX_W-1:0];
  assign w_cand_ok     = ({1'b0, w_cand} < PAL_LIM) && (w_cand != w_newest);
  assign w_take        = r_pend | i_advance;
  assign w_take_mode   = r_pend ? r_pend_mode : i_mode;
  assign w_unused_lfsr = ^w_lfsr;

  // Decide whether the queue shifts this cycle and with which colour
  always_comb begin
    w_commit = 1'b0;
    w_new    = w_seq;
    if (r_state == IDLE) begin
      w_commit = w_take && !w_take_mode;
    end else if (w_cand_ok) begin
      w_commit = 1'b1;
      w_new    = w_cand;
    end else if (r_tries == LAST_TRY) begin
      w_commit = 1'b1;
    end
  end

  // Draw controller: accepts advances, holds one pending advance, flags drops
  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      r_state     <= IDLE;
      r_tries     <= '0;
      r_pend      <= 1'b0;
      r_pend_mode <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pend) begin
            r_pend    <= 1'b0;
            r_overrun <= i_advance;
          end
          if (w_take && w_take_mode) begin
            r_state <= DRAW;
            r_tries <= '0;
          end
        end
        DRAW: begin
          if (i_advance) begin
            if (r_pend) begin
              r_overrun <= 1'b1;
            end else begin
              r_pend      <= 1'b1;
              r_pend_mode <= i_mode;
            end
          end
          if (w_commit) begin
            r_state <= IDLE;
          end else begin
            r_tries <= r_tries + TRY_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == DRAW);
  assign o_overrun = r_overrun;
`else
  logic w_unused_in;

  assign w_commit    = i_advance;
  assign w_new       = w_seq;
  assign o_busy      = 1'b0;
  assign o_overrun   = 1'b0;
  assign w_unused_in = ^{i_mode, i_seed_load, i_seed};
`endif

  // Index queue: shift toward box 0 on commit and pulse o_update alongside
  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      for (int k = 0; k < NUM_BOXES; k++) begin
        r_box[k] <= IDX_W'((PALETTE_SIZE - 1 + k) % PALETTE_SIZE);
      end
      r_update <= 1'b0;
    end else begin
      r_update <= w_commit;
      if (w_commit) begin
        for (int k = 0; k < NUM_BOXES - 1; k++) begin
          r_box[k] <= r_box[k+1];
        end
        r_box[NUM_BOXES-1] <= w_new;
      end
    end
  end

  for (genvar g = 0; g < NUM_BOXES; g++) begin : g_pack
    assign o_color_index[g*IDX_W +: IDX_W] = r_box[g];
  end

  assign o_update = r_update;

endmodule
